wb_burst_ram_slave: RTL and testbench

- Synthesizable Wishbone B3 slave: word-addressed RAM that answers the bus master's classic and incrementing-burst cycles.
- Byte-lane writes via sel.
- Configurable first-beat wait states.
- Flags out-of-range accesses and burst-address mismatches with err.
- Sits on the slave side of the same interconnect the master BFM drives; used in benches and as a small on-chip scratch RAM.

---
 rtl/wb_burst_ram_slave.sv | 159 +++++++++++++++
 tb/tb_wb_burst_ram_slave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_ram_slave.sv
// Wishbone B3 word-addressed RAM slave: classic and constant/incrementing bursts,
// byte-lane writes, first-beat wait states, err on out-of-range or address mismatch.
module wb_burst_ram_slave #(
  parameter int unsigned aw          = 32,
  parameter int unsigned dw          = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [aw-1:0] wb_adr_i,
  input  logic [dw-1:0] wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic [2:0]    wb_cti_i,
  input  logic [1:0]    wb_bte_i,
  output logic [dw-1:0] wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic          wb_rty_o
);

  localparam int unsigned   IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW        = 4;
  localparam logic [aw-1:0] LIMIT     = aw'(DEPTH * 4);
  localparam logic [2:0]    CTI_CONST = 3'b001;
  localparam logic [2:0]    CTI_INCR  = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_t;

  state_t          state_q, state_d;
  logic [aw-1:0]   a_q, a_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            vld_q, vld_d;     // dat_q holds the word for the current beat
  logic [dw-1:0]   dat_q, dat_d;
  logic [dw-1:0]   mem_q [DEPTH];

  logic            live_c, beat_c, bad_c, ack_c, err_c, burst_c;
  logic [aw-1:0]   a_nxt_c;
  logic [IW-1:0]   idx_c, nidx_c;
  logic [dw-1:0]   rd_word_c, wr_word_c;

  // Beat qualification: a prefetched beat terminates only while the master strobes it
  always_comb begin
    live_c  = wb_cyc_i & wb_stb_i;
    beat_c  = (state_q == S_BEAT) & vld_q & live_c;
    bad_c   = (a_q >= LIMIT) | (wb_adr_i != a_q);
    ack_c   = beat_c & ~bad_c;
    err_c   = beat_c & bad_c;
    burst_c = (wb_cti_i == CTI_INCR) | (wb_cti_i == CTI_CONST);
  end

  // Next burst address: constant holds, linear adds 4, wrapN rolls only the low beat bits
  always_comb begin
    a_nxt_c = a_q;
    if (wb_cti_i == CTI_INCR) begin
      unique case (wb_bte_i)
        2'b00:   a_nxt_c      = a_q + aw'(4);
        2'b01:   a_nxt_c[3:2] = a_q[3:2] + 2'd1;
        2'b10:   a_nxt_c[4:2] = a_q[4:2] + 3'd1;
        default: a_nxt_c[5:2] = a_q[5:2] + 4'd1;
      endcase
    end
  end

  // Word indices and the byte-lane merge of the write data into the current word
  always_comb begin
    idx_c     = a_q[IW+1:2];
    nidx_c    = a_nxt_c[IW+1:2];
    rd_word_c = mem_q[idx_c];
    wr_word_c = rd_word_c;
    for (int i = 0; i < 4; i++) begin
      if (wb_sel_i[i]) wr_word_c[8*i +: 8] = wb_dat_i[8*i +: 8];
    end
  end

  // Next-state logic: latch, optional wait countdown, fetch, then ack/err beats
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    dat_d   = dat_q;
    unique case (state_q)
      S_IDLE: begin
        vld_d = 1'b0;
        if (live_c) begin
          a_d = wb_adr_i;
          if (WAIT_STATES == 0) begin
            state_d = S_BEAT;
          end else begin
            cnt_d   = CW'(WAIT_STATES);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_BEAT;
        end
      end
      S_BEAT: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
          vld_d   = 1'b0;
        end else if (!vld_q) begin
          vld_d = 1'b1;
          dat_d = rd_word_c;
        end else if (err_c) begin
          state_d = S_IDLE;
          vld_d   = 1'b0;
        end else if (ack_c) begin
          if (burst_c) begin
            a_d   = a_nxt_c;
            // A constant-address write must be visible to the following beat
            dat_d = (wb_cti_i == CTI_CONST && wb_we_i) ? wr_word_c : mem_q[nidx_c];
          end else begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
    end
  end

  // RAM write at the edge that ends an acked write beat; contents survive reset
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && ack_c && wb_we_i) mem_q[idx_c] <= wr_word_c;
  end

  assign wb_ack_o = ack_c;
  assign wb_err_o = err_c;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = ack_c ? dat_q : '0;

endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// Bench for wb_burst_ram_slave: one instance with no wait states, one with three.
module tb_wb_burst_ram_slave;

  localparam logic [31:0] LIMIT = 32'h400;

  logic        clk;
  logic        rst;
  logic        cyc0, cyc3, stb, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] rdat0, rdat3;
  logic        ack0, err0, rty0, ack3, err3, rty3;

  int          d;
  logic [31:0] rdat;
  logic        ack, err, rty;

  int          ntests, nfail;
  logic [31:0] ref_mem [2][256];

  int          p_n;
  logic        p_we;
  logic [1:0]  p_bte;
  logic [31:0] m_adr [16];
  logic [31:0] b_adr [16];
  logic [31:0] b_dat [16];
  logic [3:0]  b_sel [16];
  logic [2:0]  b_cti [16];
  int          b_stall [16];
  logic        b_experr [16];
  logic [31:0] last_rd;

  wb_burst_ram_slave #(.aw(32), .dw(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc0), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(rdat0), .wb_ack_o(ack0), .wb_err_o(err0), .wb_rty_o(rty0)
  );

  wb_burst_ram_slave #(.aw(32), .dw(32), .DEPTH(256), .WAIT_STATES(3)) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc3), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(rdat3), .wb_ack_o(ack3), .wb_err_o(err3), .wb_rty_o(rty3)
  );

  assign rdat = (d == 1) ? rdat3 : rdat0;
  assign ack  = (d == 1) ? ack3  : ack0;
  assign err  = (d == 1) ? err3  : err0;
  assign rty  = (d == 1) ? rty3  : rty0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_cyc(input logic v);
    if (d == 1) cyc3 = v; else cyc0 = v;
  endtask

  // Spec address rule: linear +4 over all bits; wrapN keeps bits above the N-beat window
  function automatic logic [31:0] next_adr(input logic [31:0] a, input logic [1:0] bt, input logic incr);
    logic [31:0] span;
    if (!incr) return a;
    if (bt == 2'b00) return a + 32'd4;
    span = 32'd16 << (bt - 2'd1);
    return (a & ~(span - 32'd1)) | ((a + 32'd4) & (span - 32'd1));
  endfunction

  task automatic mark_err(input int n);
    for (int i = 0; i < n; i++)
      b_experr[i] = (b_adr[i] != m_adr[i]) || (m_adr[i] >= LIMIT);
  endtask

  task automatic plan(input int n, input logic [31:0] a0, input logic [1:0] bt, input logic incr,
                      input logic w, input int stall_max, input logic fullsel);
    logic [31:0] a;
    a = a0; p_n = n; p_we = w; p_bte = bt;
    for (int i = 0; i < n; i++) begin
      m_adr[i]   = a;
      b_adr[i]   = a;
      b_dat[i]   = $urandom;
      b_sel[i]   = fullsel ? 4'hF : 4'($urandom_range(1, 15));
      b_cti[i]   = (n == 1) ? 3'b000 : (i == n - 1) ? 3'b111 : (incr ? 3'b010 : 3'b001);
      b_stall[i] = (i > 0) ? $urandom_range(0, stall_max) : 0;
      a = next_adr(a, bt, incr);
    end
    mark_err(n);
  endtask

  // Drives one planned cycle; entered and left just after a rising edge
  task automatic run_burst();
    int          lat;
    logic        e;
    logic [31:0] w;
    int          idx;
    bte = p_bte; we = p_we; stb = 1'b1; set_cyc(1'b1);
    for (int i = 0; i < p_n; i++) begin
      adr = b_adr[i]; wdat = b_dat[i]; sel = b_sel[i]; cti = b_cti[i];
      if (b_stall[i] > 0) begin
        stb = 1'b0;
        repeat (b_stall[i]) begin
          @(negedge clk);
          check("stall_quiet", {30'd0, ack, err}, 32'd0);
          @(posedge clk); #1;
        end
        stb = 1'b1;
      end
      lat = 0;
      do begin @(negedge clk); lat++; end while (!(ack || err) && lat < 40);
      check("latency", 32'(lat), (i == 0) ? 32'(3 + 3 * d) : 32'd1);
      e = b_experr[i];
      check("ack", 32'(ack), 32'(!e));
      check("err", 32'(err), 32'(e));
      check("rty", 32'(rty), 32'd0);
      idx = int'(m_adr[i][9:2]);
      if (e) begin
        check("err_dat", rdat, 32'd0);
      end else if (!p_we) begin
        last_rd = rdat;
        check("rdata", rdat, ref_mem[d][idx]);
      end else begin
        w = ref_mem[d][idx];
        for (int j = 0; j < 4; j++) if (b_sel[i][j]) w[8*j +: 8] = b_dat[i][8*j +: 8];
        ref_mem[d][idx] = w;
      end
      @(posedge clk); #1;
      if (e) break;
    end
    stb = 1'b0; set_cyc(1'b0); cti = 3'b000;
    @(negedge clk);
    check("post_quiet", {30'd0, ack, err}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic random_bursts(input int count);
    int          n, j;
    logic [31:0] a0;
    for (int r = 0; r < count; r++) begin
      n = $urandom_range(1, 6);
      if ($urandom_range(0, 7) == 0) a0 = LIMIT + 32'(4 * $urandom_range(0, 15));
      else                           a0 = 32'(4 * $urandom_range(0, 255));
      plan(n, a0, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 2, 1'b0);
      if (n > 1 && $urandom_range(0, 5) == 0) begin
        j = $urandom_range(1, n - 1);
        b_adr[j] = b_adr[j] ^ 32'h4;
        mark_err(n);
      end
      run_burst();
    end
  endtask

  initial begin
    int lat;
    ntests = 0; nfail = 0; d = 0; last_rd = '0;
    rst = 1'b1; cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; sel = '0; cti = '0; bte = '0;

    // Reset state of both instances
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack0", 32'(ack0), 32'd0);  check("rst_err0", 32'(err0), 32'd0);
    check("rst_rty0", 32'(rty0), 32'd0);  check("rst_dat0", rdat0, 32'd0);
    check("rst_ack3", 32'(ack3), 32'd0);  check("rst_err3", 32'(err3), 32'd0);
    check("rst_rty3", 32'(rty3), 32'd0);  check("rst_dat3", rdat3, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill both RAMs with random words through linear write bursts
    for (int dd = 0; dd < 2; dd++) begin
      d = dd;
      for (int b = 0; b < 16; b++) begin
        plan(16, 32'(b * 64), 2'b00, 1'b1, 1'b1, 0, 1'b1);
        run_burst();
      end
    end

    // Classic write/read and byte-lane merge, no wait states
    d = 0;
    plan(1, 32'h10, 2'b00, 1'b0, 1'b1, 0, 1'b1); b_dat[0] = 32'hDEADBEEF; run_burst();
    plan(1, 32'h10, 2'b00, 1'b0, 1'b0, 0, 1'b1); run_burst();
    check("classic_rd", last_rd, 32'hDEADBEEF);
    plan(1, 32'h10, 2'b00, 1'b0, 1'b1, 0, 1'b1);
    b_dat[0] = 32'h000000AA; b_sel[0] = 4'b0001; run_burst();
    plan(1, 32'h10, 2'b00, 1'b0, 1'b0, 0, 1'b1); run_burst();
    check("byte_lane_rd", last_rd, 32'hDEADBEAA);

    // Linear burst write and back-to-back readback
    plan(4, 32'h20, 2'b00, 1'b1, 1'b1, 0, 1'b1); run_burst();
    plan(4, 32'h20, 2'b00, 1'b1, 1'b0, 0, 1'b1); run_burst();

    // wrap4 read from 0x38, then the same burst with a linear address on beat 3
    plan(4, 32'h38, 2'b01, 1'b1, 1'b0, 0, 1'b1); run_burst();
    plan(4, 32'h38, 2'b01, 1'b1, 1'b0, 0, 1'b1); b_adr[2] = 32'h40; mark_err(4); run_burst();

    // Out-of-range read and write, then word 0 must be untouched
    plan(1, 32'h400, 2'b00, 1'b0, 1'b0, 0, 1'b1); run_burst();
    plan(1, 32'h400, 2'b00, 1'b0, 1'b1, 0, 1'b1); run_burst();
    plan(1, 32'h000, 2'b00, 1'b0, 1'b0, 0, 1'b1); run_burst();

    random_bursts(25);

    // Three wait states: classic access and a stalled burst
    d = 1;
    plan(1, 32'h44, 2'b00, 1'b0, 1'b1, 0, 1'b1); run_burst();
    plan(1, 32'h44, 2'b00, 1'b0, 1'b0, 0, 1'b1); run_burst();
    plan(4, 32'h80, 2'b00, 1'b1, 1'b1, 0, 1'b1); b_stall[1] = 2; b_stall[3] = 1; run_burst();
    plan(4, 32'h80, 2'b00, 1'b1, 1'b0, 0, 1'b1); b_stall[2] = 2; run_burst();

    // Reset pulsed in the middle of a burst abandons it
    set_cyc(1'b1); stb = 1'b1; we = 1'b0; adr = 32'h80; cti = 3'b010; bte = 2'b00;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ack && lat < 40);
    check("mid_rst_lat", 32'(lat), 32'd6);
    @(posedge clk); #1;
    adr = 32'h84; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    rst = 1'b0; stb = 1'b0; set_cyc(1'b0); cti = 3'b000;
    @(posedge clk); #1;
    plan(1, 32'h84, 2'b00, 1'b0, 1'b0, 0, 1'b1); run_burst();

    random_bursts(25);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
